// File: rtl/alu_operand_stage_pkg.sv
// Shared constants for the ID/EX operand stage: datapath widths and ALU op codes.
package alu_operand_stage_pkg;

    localparam int WIDTH  = 16;
    localparam int REG_AW = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_AND = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Bypass select for one ALU operand. EX/MEM beats MEM/WB; a load in EX/MEM has
// no data yet, so it never forwards from that port.
module operand_fwd_mux
    import alu_operand_stage_pkg::*;
#(
    parameter int W  = WIDTH,
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] i_src,
    input  logic [W-1:0]  i_rf_data,
    input  logic          i_exm_valid,
    input  logic          i_exm_reg_write,
    input  logic          i_exm_is_load,
    input  logic [AW-1:0] i_exm_rd,
    input  logic [W-1:0]  i_exm_result,
    input  logic          i_wb_valid,
    input  logic          i_wb_reg_write,
    input  logic [AW-1:0] i_wb_rd,
    input  logic [W-1:0]  i_wb_data,
    output logic [W-1:0]  o_data,
    output logic          o_hit
);

    // Priority bypass: EX/MEM, then MEM/WB, then stored register-file data.
    always_comb begin
        o_data = i_rf_data;
        o_hit  = 1'b0;
        if (i_exm_valid && i_exm_reg_write && !i_exm_is_load && (i_exm_rd == i_src)) begin
            o_data = i_exm_result;
            o_hit  = 1'b1;
        end else if (i_wb_valid && i_wb_reg_write && (i_wb_rd == i_src)) begin
            o_data = i_wb_data;
            o_hit  = 1'b1;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register stage for the 16-bit ALU: captures operands and control,
// bypasses later results onto ex_A/ex_B, and stalls decode on load-use.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int W  = WIDTH,
    parameter int AW = REG_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [W-1:0]  id_rs_data,
    input  logic [W-1:0]  id_rt_data,
    input  logic [W-1:0]  id_imm,
    input  logic          id_use_imm,
    input  logic [1:0]    id_op,
    input  logic          id_cin,
    input  logic          id_sign,
    input  logic [AW-1:0] id_rd,
    input  logic          id_reg_write,
    input  logic          id_is_load,
    output logic          id_stall,
    input  logic          flush,
    input  logic          ex_stall,
    input  logic          exm_valid,
    input  logic          exm_reg_write,
    input  logic          exm_is_load,
    input  logic [AW-1:0] exm_rd,
    input  logic [W-1:0]  exm_result,
    input  logic          wb_valid,
    input  logic          wb_reg_write,
    input  logic [AW-1:0] wb_rd,
    input  logic [W-1:0]  wb_data,
    output logic          ex_valid,
    output logic [W-1:0]  ex_A,
    output logic [W-1:0]  ex_B,
    output logic          ex_Cin,
    output logic          ex_sign,
    output logic [1:0]    ex_Op,
    output logic [AW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic          ex_is_load
);

    logic          r_valid;
    logic [AW-1:0] r_rs;
    logic [AW-1:0] r_rt;
    logic [W-1:0]  r_rs_data;
    logic [W-1:0]  r_rt_data;
    logic [W-1:0]  r_imm;
    logic          r_use_imm;
    alu_op_e       r_op;
    logic          r_cin;
    logic          r_sign;
    logic [AW-1:0] r_rd;
    logic          r_reg_write;
    logic          r_is_load;

    logic [W-1:0]  w_a_fwd;
    logic [W-1:0]  w_b_fwd;
    logic          w_a_hit;
    logic          w_b_hit;
    logic          w_haz;
    logic          w_capture;

    operand_fwd_mux #(.W(W), .AW(AW)) u_fwd_a (
        .i_src           (r_rs),
        .i_rf_data       (r_rs_data),
        .i_exm_valid     (exm_valid),
        .i_exm_reg_write (exm_reg_write),
        .i_exm_is_load   (exm_is_load),
        .i_exm_rd        (exm_rd),
        .i_exm_result    (exm_result),
        .i_wb_valid      (wb_valid),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_data       (wb_data),
        .o_data          (w_a_fwd),
        .o_hit           (w_a_hit)
    );

    operand_fwd_mux #(.W(W), .AW(AW)) u_fwd_b (
        .i_src           (r_rt),
        .i_rf_data       (r_rt_data),
        .i_exm_valid     (exm_valid),
        .i_exm_reg_write (exm_reg_write),
        .i_exm_is_load   (exm_is_load),
        .i_exm_rd        (exm_rd),
        .i_exm_result    (exm_result),
        .i_wb_valid      (wb_valid),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_data       (wb_data),
        .o_data          (w_b_fwd),
        .o_hit           (w_b_hit)
    );

    // Load-use detect against the instruction currently in EX; capture only when nothing blocks.
    always_comb begin
        w_haz = r_valid && r_is_load && r_reg_write && id_valid &&
                ((r_rd == id_rs) || (!id_use_imm && (r_rd == id_rt)));
        w_capture = id_valid && !w_haz && !ex_stall;
    end

    assign id_stall     = w_haz || ex_stall;
    assign ex_valid     = r_valid;
    assign ex_A         = w_a_fwd;
    assign ex_B         = r_use_imm ? r_imm : w_b_fwd;
    assign ex_Cin       = r_cin;
    assign ex_sign      = r_sign;
    assign ex_Op        = r_op;
    assign ex_rd        = r_rd;
    assign ex_reg_write = r_reg_write;
    assign ex_is_load   = r_is_load;

    // Stage register: reset, then flush > hold > capture > bubble. A hold folds any
    // live bypass into the stored operands so a retiring WB value survives the stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_op        <= OP_ADD;
            r_cin       <= 1'b0;
            r_sign      <= 1'b0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_is_load   <= 1'b0;
        end else if (!flush && ex_stall) begin
            if (w_a_hit) r_rs_data <= w_a_fwd;
            if (w_b_hit) r_rt_data <= w_b_fwd;
        end else begin
            r_rs      <= id_rs;
            r_rt      <= id_rt;
            r_rs_data <= id_rs_data;
            r_rt_data <= id_rt_data;
            r_imm     <= id_imm;
            r_use_imm <= id_use_imm;
            r_rd      <= id_rd;
            if (!flush && w_capture) begin
                r_valid     <= 1'b1;
                r_op        <= alu_op_e'(id_op);
                r_cin       <= id_cin;
                r_sign      <= id_sign;
                r_reg_write <= id_reg_write;
                r_is_load   <= id_is_load;
            end else begin
                r_valid     <= 1'b0;
                r_op        <= OP_ADD;
                r_cin       <= 1'b0;
                r_sign      <= 1'b0;
                r_reg_write <= 1'b0;
                r_is_load   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed checks for the ID/EX operand stage: capture, bypass priority, load-use
// bubble, hold refresh, flush, immediate operand and reset during hold.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_use_imm;
    logic [1:0]  id_op;
    logic        id_cin, id_sign, id_reg_write, id_is_load;
    logic        id_stall;
    logic        flush, ex_stall;
    logic        exm_valid, exm_reg_write, exm_is_load;
    logic [2:0]  exm_rd;
    logic [15:0] exm_result;
    logic        wb_valid, wb_reg_write;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        ex_valid;
    logic [15:0] ex_A, ex_B;
    logic        ex_Cin, ex_sign;
    logic [1:0]  ex_Op;
    logic [2:0]  ex_rd;
    logic        ex_reg_write, ex_is_load;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_op(id_op), .id_cin(id_cin), .id_sign(id_sign),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .id_stall(id_stall), .flush(flush), .ex_stall(ex_stall),
        .exm_valid(exm_valid), .exm_reg_write(exm_reg_write), .exm_is_load(exm_is_load),
        .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_Cin(ex_Cin), .ex_sign(ex_sign),
        .ex_Op(ex_Op), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [2:0] rs, input logic [15:0] rsd,
                          input logic [2:0] rt, input logic [15:0] rtd,
                          input logic [1:0] op, input logic [2:0] rd, input logic ld);
        id_valid = v; id_rs = rs; id_rs_data = rsd; id_rt = rt; id_rt_data = rtd;
        id_op = op; id_rd = rd; id_reg_write = 1'b1; id_is_load = ld;
        id_use_imm = 1'b0; id_imm = '0; id_cin = 1'b0; id_sign = 1'b0;
    endtask

    task automatic bypass_off();
        exm_valid = 0; exm_reg_write = 0; exm_is_load = 0; exm_rd = 0; exm_result = 0;
        wb_valid = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    endtask

    initial begin
        rst_n = 0; flush = 0; ex_stall = 0;
        set_id(1'b0, 3'd0, 16'h0, 3'd0, 16'h0, 2'b00, 3'd0, 1'b0);
        id_reg_write = 0;
        bypass_off();

        // 1. reset then capture
        tick(); tick();
        chk("rst_valid", ex_valid, 0);
        chk("rst_A", ex_A, 0);
        chk("rst_B", ex_B, 0);
        chk("rst_ctrl", {ex_Op, ex_rd, ex_reg_write, ex_is_load, ex_Cin}, 0);
        rst_n = 1;
        set_id(1'b1, 3'd1, 16'd5, 3'd2, 16'd7, 2'b00, 3'd5, 1'b0);
        tick();
        chk("cap_valid", ex_valid, 1);
        chk("cap_A", ex_A, 5);
        chk("cap_B", ex_B, 7);
        chk("cap_Op", ex_Op, 0);
        chk("cap_rd", ex_rd, 5);

        // 2. bypass priority on rs=r3
        set_id(1'b1, 3'd3, 16'h0011, 3'd6, 16'h0022, 2'b01, 3'd7, 1'b0);
        id_cin = 1;
        tick();
        id_valid = 0;
        exm_valid = 1; exm_reg_write = 1; exm_rd = 3; exm_result = 16'h00FF;
        wb_valid = 1; wb_reg_write = 1; wb_rd = 3; wb_data = 16'h1234;
        #1;
        chk("fwd_exm_A", ex_A, 16'h00FF);
        chk("fwd_B_rf", ex_B, 16'h0022);
        chk("fwd_Op_Cin", {ex_Op, ex_Cin}, {2'b01, 1'b1});
        exm_is_load = 1; #1;
        chk("fwd_exm_load_blocked", ex_A, 16'h1234);
        exm_valid = 0; exm_is_load = 0; #1;
        chk("fwd_wb_A", ex_A, 16'h1234);
        bypass_off(); #1;
        chk("fwd_none_A", ex_A, 16'h0011);
        tick();
        chk("idle_bubble", ex_valid, 0);

        // 3. load-use on r4
        set_id(1'b1, 3'd1, 16'h0, 3'd2, 16'h0, 2'b00, 3'd4, 1'b1);
        tick();
        chk("ld_valid", {ex_valid, ex_is_load}, 2'b11);
        set_id(1'b1, 3'd4, 16'h0BAD, 3'd5, 16'h0003, 2'b10, 3'd6, 1'b0);
        #1;
        chk("lu_stall", id_stall, 1);
        tick();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_bubble_ctrl", {ex_reg_write, ex_is_load}, 0);
        chk("lu_stall_clear", id_stall, 0);
        exm_valid = 1; exm_reg_write = 1; exm_is_load = 1; exm_rd = 4; exm_result = 16'h7777;
        tick();
        bypass_off();
        wb_valid = 1; wb_reg_write = 1; wb_rd = 4; wb_data = 16'hCAFE;
        #1;
        chk("lu_cap_valid", ex_valid, 1);
        chk("lu_A_wb", ex_A, 16'hCAFE);
        chk("lu_B", ex_B, 16'h0003);
        chk("lu_Op", ex_Op, 2'b10);

        // 4. hold with WB refresh (rs=r4, rt=r5)
        set_id(1'b1, 3'd1, 16'h1111, 3'd2, 16'h2222, 2'b11, 3'd3, 1'b0);
        ex_stall = 1;
        #1;
        chk("hold_id_stall", id_stall, 1);
        tick();
        wb_rd = 5; wb_data = 16'hBEEF;
        #1;
        chk("hold1_valid", ex_valid, 1);
        chk("hold1_Op", ex_Op, 2'b10);
        chk("hold2_B_fwd", ex_B, 16'hBEEF);
        tick();
        bypass_off();
        tick();
        ex_stall = 0;
        #1;
        chk("hold_rel_B", ex_B, 16'hBEEF);
        chk("hold_rel_A", ex_A, 16'hCAFE);
        chk("hold_rel_rd", ex_rd, 6);
        chk("hold_rel_stall", id_stall, 0);
        tick();
        chk("post_hold_A", ex_A, 16'h1111);
        chk("post_hold_B", ex_B, 16'h2222);
        chk("post_hold_Op", ex_Op, 2'b11);

        // 5. flush against stall, and flush against capture
        flush = 1; ex_stall = 1;
        #1;
        chk("flush_stall_id", id_stall, 1);
        tick();
        chk("flush_stall_valid", ex_valid, 0);
        ex_stall = 0;
        #1;
        chk("flush_id_stall", id_stall, 0);
        tick();
        chk("flush_cap_valid", ex_valid, 0);
        flush = 0;

        // 6. immediate B with rt matching a load in EX and an EX/MEM write
        set_id(1'b1, 3'd0, 16'h0, 3'd0, 16'h0, 2'b00, 3'd2, 1'b1);
        tick();
        set_id(1'b1, 3'd1, 16'h0042, 3'd2, 16'h5555, 2'b00, 3'd1, 1'b0);
        id_use_imm = 1; id_imm = 16'hFFF0;
        exm_valid = 1; exm_reg_write = 1; exm_rd = 2; exm_result = 16'h9999;
        #1;
        chk("imm_no_stall", id_stall, 0);
        tick();
        chk("imm_B", ex_B, 16'hFFF0);
        chk("imm_A", ex_A, 16'h0042);
        chk("imm_valid", ex_valid, 1);

        // 7. reset during hold
        bypass_off();
        ex_stall = 1; rst_n = 0;
        tick();
        chk("rst_hold_valid", ex_valid, 0);
        chk("rst_hold_AB", {ex_A, ex_B}, 0);
        chk("rst_hold_rd", ex_rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
